// File: rtl/traffic_light_fsm_if.sv
// Signal bundle between the intersection controller and its environment:
// roll-counter tick and pedestrian button in, lamp drives and walk acknowledge out.
interface traffic_light_fsm_if;
    logic       tick;
    logic       ped_req;
    logic [2:0] ns_lamp;
    logic [2:0] ew_lamp;
    logic       walk;
    logic       ped_ack;

    modport master (
        output tick, ped_req,
        input  ns_lamp, ew_lamp, walk, ped_ack
    );

    modport slave (
        input  tick, ped_req,
        output ns_lamp, ew_lamp, walk, ped_ack
    );
endinterface

// File: rtl/traffic_light_fsm.sv
// Two-way intersection phase sequencer: green, yellow, all-red, optional walk,
// paced by the upstream roll-counter tick. Lamps decode state and direction directly.
module traffic_light_fsm #(
    parameter int unsigned GREEN_TICKS  = 8,
    parameter int unsigned YELLOW_TICKS = 3,
    parameter int unsigned RED_TICKS    = 2,
    parameter int unsigned WALK_TICKS   = 4,
    parameter int unsigned TW           = 8
) (
    input logic                 clk,
    input logic                 reset_n,
    traffic_light_fsm_if.slave  bus
);

    typedef enum logic [1:0] {
        GREEN   = 2'd0,
        YELLOW  = 2'd1,
        ALL_RED = 2'd2,
        WALK    = 2'd3
    } state_t;

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;

    localparam logic [TW-1:0] G_LAST = TW'(GREEN_TICKS - 1);
    localparam logic [TW-1:0] Y_LAST = TW'(YELLOW_TICKS - 1);
    localparam logic [TW-1:0] R_LAST = TW'(RED_TICKS - 1);
    localparam logic [TW-1:0] W_LAST = TW'(WALK_TICKS - 1);

    state_t         r_state;
    logic           r_dir;
    logic [TW-1:0]  r_timer;
    logic           r_ped_pending;
    logic           r_ped_ack;

    state_t         w_state_nxt;
    logic           w_dir_nxt;
    logic [TW-1:0]  w_timer_nxt;
    logic           w_ped_nxt;
    logic           w_enter_walk;
    logic [TW-1:0]  w_last;
    logic           w_final;
    logic [2:0]     w_active_lamp;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= GREEN;
            r_dir         <= 1'b0;
            r_timer       <= '0;
            r_ped_pending <= 1'b0;
            r_ped_ack     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_dir         <= w_dir_nxt;
            r_timer       <= w_timer_nxt;
            r_ped_pending <= w_ped_nxt;
            r_ped_ack     <= w_enter_walk;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_dir_nxt   = r_dir;
        w_timer_nxt = r_timer;
        w_last      = G_LAST;

        case (r_state)
            GREEN:   w_last = G_LAST;
            YELLOW:  w_last = Y_LAST;
            ALL_RED: w_last = R_LAST;
            WALK:    w_last = W_LAST;
            default: w_last = G_LAST;
        endcase

        w_final = bus.tick && (r_timer == w_last);

        if (bus.tick) begin
            if (w_final) begin
                w_timer_nxt = '0;
                case (r_state)
                    GREEN:   w_state_nxt = YELLOW;
                    YELLOW:  w_state_nxt = ALL_RED;
                    ALL_RED: begin
                        // dir flips on every all-red exit; a walk phase keeps the flipped value
                        w_dir_nxt = ~r_dir;
                        w_state_nxt = r_ped_pending ? WALK : GREEN;
                    end
                    WALK:    w_state_nxt = GREEN;
                    default: w_state_nxt = GREEN;
                endcase
            end else begin
                w_timer_nxt = r_timer + 1'b1;
            end
        end

        w_enter_walk = (w_state_nxt == WALK) && (r_state != WALK);

        // Clearing on walk entry outranks a request landing on the same edge
        w_ped_nxt = r_ped_pending;
        if (w_enter_walk) begin
            w_ped_nxt = 1'b0;
        end else if (bus.ped_req && (r_state != WALK)) begin
            w_ped_nxt = 1'b1;
        end
    end

    always_comb begin
        w_active_lamp = LAMP_RED;
        bus.ns_lamp   = LAMP_RED;
        bus.ew_lamp   = LAMP_RED;
        bus.walk      = 1'b0;
        bus.ped_ack   = r_ped_ack;

        case (r_state)
            GREEN:   w_active_lamp = LAMP_GREEN;
            YELLOW:  w_active_lamp = LAMP_YELLOW;
            default: w_active_lamp = LAMP_RED;
        endcase

        if (r_dir) begin
            bus.ew_lamp = w_active_lamp;
        end else begin
            bus.ns_lamp = w_active_lamp;
        end

        bus.walk = (r_state == WALK);
    end

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Scoreboard bench for traffic_light_fsm: directed phase walks with hand-computed
// lamp expectations, async reset check, and a random run guarding lamp safety.
module tb_traffic_light_fsm;

    typedef enum int unsigned {NSG, NSY, AR, WK, EWG, EWY} ph_t;

    typedef struct {
        int unsigned due;
        ph_t         ph;
        logic        ack;
        int unsigned tid;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    int unsigned cyc = 0;
    int unsigned test_id = 0;
    int          checks = 0;
    int          errors = 0;
    logic        prev_ack = 1'b0;
    exp_t        q[$];

    traffic_light_fsm_if bus ();

    traffic_light_fsm #(
        .GREEN_TICKS (8),
        .YELLOW_TICKS(3),
        .RED_TICKS   (2),
        .WALK_TICKS  (4),
        .TW          (8)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [6:0] pat(input ph_t p);
        case (p)
            NSG:     pat = {3'b001, 3'b100, 1'b0};
            NSY:     pat = {3'b010, 3'b100, 1'b0};
            AR:      pat = {3'b100, 3'b100, 1'b0};
            WK:      pat = {3'b100, 3'b100, 1'b1};
            EWG:     pat = {3'b100, 3'b001, 1'b0};
            EWY:     pat = {3'b100, 3'b010, 1'b0};
            default: pat = 7'h00;
        endcase
    endfunction

    task automatic cmp(input string nm, input int unsigned tid,
                       input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s test%0d cyc%0d: got ns/ew/walk/ack=%b expected %b",
                     nm, tid, cyc, act, req);
        end
    endtask

    function automatic logic [7:0] dut_out();
        return {bus.ns_lamp, bus.ew_lamp, bus.walk, bus.ped_ack};
    endfunction

    task automatic push(input ph_t ph, input logic ack);
        exp_t e;
        e.due = cyc + 1;
        e.ph  = ph;
        e.ack = ack;
        e.tid = test_id;
        q.push_back(e);
    endtask

    // Monitor: safety invariants every cycle, then pop whatever expectations are due
    always @(negedge clk) begin
        exp_t e;
        if (reset_n === 1'b1) begin
            checks++;
            if (bus.ns_lamp != 3'b100 && bus.ew_lamp != 3'b100) begin
                errors++;
                $display("FAIL lamp_safety cyc%0d: got ns=%b ew=%b expected one red", cyc, bus.ns_lamp, bus.ew_lamp);
            end
            checks++;
            if ((bus.ped_ack && !bus.walk) || (bus.ped_ack && prev_ack)) begin
                errors++;
                $display("FAIL ack_pulse cyc%0d: got ack=%b walk=%b prev_ack=%b expected single ack inside walk",
                         cyc, bus.ped_ack, bus.walk, prev_ack);
            end
        end
        prev_ack = bus.ped_ack;
        while (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            cmp("phase", e.tid, dut_out(), {pat(e.ph), e.ack});
        end
    end

    // One tick cycle followed by one idle cycle; hold keeps ped_req up through the idle cycle
    task automatic tk(input logic ped, input logic hold, input ph_t ph, input logic ack);
        @(negedge clk);
        bus.tick    = 1'b1;
        bus.ped_req = ped;
        push(ph, ack);
        @(negedge clk);
        bus.tick    = 1'b0;
        bus.ped_req = hold ? ped : 1'b0;
        push(ph, 1'b0);
    endtask

    // Ticks 1..11 of a cycle: 7 green, 3 yellow, first all-red tick
    task automatic to_allred(input ph_t g, input ph_t y, input logic ped_first);
        tk(ped_first, 1'b0, g, 1'b0);
        for (int i = 2; i <= 7; i++) tk(1'b0, 1'b0, g, 1'b0);
        for (int i = 8; i <= 10; i++) tk(1'b0, 1'b0, y, 1'b0);
        tk(1'b0, 1'b0, AR, 1'b0);
    endtask

    task automatic walk_rest(input ph_t after);
        for (int i = 0; i < 3; i++) tk(1'b0, 1'b0, WK, 1'b0);
        tk(1'b0, 1'b0, after, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n     = 1'b0;
        bus.tick    = 1'b0;
        bus.ped_req = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        push(NSG, 1'b0);
    endtask

    initial begin
        int unsigned ticks;
        reset_n     = 1'b0;
        bus.tick    = 1'b0;
        bus.ped_req = 1'b0;
        #1;
        cmp("reset_async_start", 0, dut_out(), {pat(NSG), 1'b0});
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        push(NSG, 1'b0);

        // Full cycle with no request: NS green 7, yellow at tick 8, EW green at tick 13
        test_id = 1;
        to_allred(NSG, NSY, 1'b0);
        tk(1'b0, 1'b0, AR, 1'b0);
        tk(1'b0, 1'b0, EWG, 1'b0);

        // Single-cycle request during NS green -> walk after all-red, then EW green
        test_id = 2;
        do_reset();
        to_allred(NSG, NSY, 1'b1);
        tk(1'b0, 1'b0, AR, 1'b0);
        tk(1'b0, 1'b0, WK, 1'b1);
        walk_rest(EWG);

        // Request held through the whole walk is absorbed; next all-red skips walk
        test_id = 3;
        to_allred(EWG, EWY, 1'b1);
        tk(1'b0, 1'b0, AR, 1'b0);
        tk(1'b0, 1'b0, WK, 1'b1);
        for (int i = 0; i < 3; i++) tk(1'b1, 1'b1, WK, 1'b0);
        tk(1'b1, 1'b0, NSG, 1'b0);
        to_allred(NSG, NSY, 1'b0);
        tk(1'b0, 1'b0, AR, 1'b0);
        tk(1'b0, 1'b0, EWG, 1'b0);

        // Request on the very edge that enters walk: one walk only
        test_id = 4;
        to_allred(EWG, EWY, 1'b1);
        tk(1'b0, 1'b0, AR, 1'b0);
        tk(1'b1, 1'b0, WK, 1'b1);
        walk_rest(NSG);
        to_allred(NSG, NSY, 1'b0);
        tk(1'b0, 1'b0, AR, 1'b0);
        tk(1'b0, 1'b0, EWG, 1'b0);

        // Request arriving in all-red before its final tick is served at that exit
        test_id = 5;
        to_allred(EWG, EWY, 1'b0);
        tk(1'b1, 1'b0, AR, 1'b0);
        tk(1'b0, 1'b0, WK, 1'b1);
        walk_rest(NSG);

        // Async reset mid-yellow with a request pending; pending must be discarded
        test_id = 6;
        for (int i = 1; i <= 7; i++) tk(1'b0, 1'b0, NSG, 1'b0);
        tk(1'b0, 1'b0, NSY, 1'b0);
        tk(1'b1, 1'b0, NSY, 1'b0);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1 cmp("reset_async_midyellow", test_id, dut_out(), {pat(NSG), 1'b0});
        @(negedge clk);
        reset_n = 1'b1;
        to_allred(NSG, NSY, 1'b0);
        tk(1'b0, 1'b0, AR, 1'b0);
        tk(1'b0, 1'b0, EWG, 1'b0);

        // Random run: monitor invariants only
        test_id = 7;
        ticks = 0;
        while (ticks < 2000) begin
            @(negedge clk);
            bus.tick    = ($urandom_range(0, 2) == 0);
            bus.ped_req = ($urandom_range(0, 19) == 0);
            if (bus.tick) ticks++;
        end
        @(negedge clk);
        bus.tick    = 1'b0;
        bus.ped_req = 1'b0;

        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
